// File: rtl/char_rotator.sv
// Four-slot character rotator driving four active-low 7-seg digits.
// Optional step counter output STEP enabled by defining CHAR_ROTATOR_STEPCNT_EN.

module char_rotator_seg (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] code,
  output logic [6:0] hex
);
  always_ff @(posedge clk) begin
    if (rst) hex <= 7'b1111111;
    else begin
      case (code)
        2'b00:   hex <= 7'b0100001;  // d
        2'b01:   hex <= 7'b0000110;  // E
        2'b10:   hex <= 7'b1111001;  // 1
        default: hex <= 7'b1111111;  // blank
      endcase
    end
  end
endmodule

module char_rotator #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] CHAR,
  input  logic       LOAD,
  input  logic       RUN,
  output logic       TICK,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
`ifdef CHAR_ROTATOR_STEPCNT_EN
  ,
  output logic [3:0] STEP
`endif
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][1:0] slot;
  logic [NUM_LANES-1:0][6:0] hex;
  logic [CW-1:0]             cnt;
  logic                      load_q;
  logic                      first;
  logic [1:0]                vld_pipe;
  logic                      auto_step, man_step, step;

  assign auto_step = RUN && (cnt == LAST);
  // A LOAD held high across reset release is not an edge.
  assign man_step  = !RUN && LOAD && !load_q && !first;
  assign step      = auto_step || man_step;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      slot     <= '1;
      cnt      <= '0;
      load_q   <= 1'b0;
      first    <= 1'b1;
      vld_pipe <= '0;
    end else begin
      load_q   <= LOAD;
      first    <= 1'b0;
      vld_pipe <= {vld_pipe[0], step};
      if (RUN) cnt <= auto_step ? '0 : cnt + 1'b1;
      if (step) slot <= {slot[2], slot[1], slot[0], (LOAD ? CHAR : slot[3])};
    end
  end

  // Slot update at edge N, TICK aligned with the display refresh at N+1.
  assign TICK = vld_pipe[1];

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      char_rotator_seg u_seg (
        .clk  (CLOCK_50),
        .rst  (RESET),
        .code (slot[g]),
        .hex  (hex[g])
      );
    end
  endgenerate

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];

`ifdef CHAR_ROTATOR_STEPCNT_EN
  logic [3:0] stepcnt;
  always_ff @(posedge CLOCK_50) begin
    if (RESET)            stepcnt <= '0;
    else if (vld_pipe[0]) stepcnt <= stepcnt + 1'b1;
  end
  assign STEP = stepcnt;
`endif
endmodule
